// File: rtl/fwd_hazard_if.sv
// Bundle of pipeline-register fields feeding the forwarding/hazard unit and the
// select, stall and multiplier-status signals it returns.
interface fwd_hazard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_valid;
  logic                     id_mul_start;
  logic [REG_W-1:0]         id_mul_rd;
  logic [NUM_SRC*REG_W-1:0] id_ex_src;
  logic                     id_ex_mem_read;
  logic [REG_W-1:0]         id_ex_rd;
  logic [REG_W-1:0]         ex_mem_rd;
  logic                     ex_mem_regwrite;
  logic [REG_W-1:0]         mem_wb_rd;
  logic                     mem_wb_regwrite;
  logic [2*NUM_SRC-1:0]     forward_sel;
  logic [NUM_SRC-1:0]       id_mul_bypass;
  logic                     pc_write;
  logic                     if_id_write;
  logic                     id_ex_bubble;
  logic                     mul_busy;
  logic                     mul_done;
  logic [REG_W-1:0]         mul_wb_rd;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output id_src, id_src_valid, id_mul_start, id_mul_rd, id_ex_src,
           id_ex_mem_read, id_ex_rd, ex_mem_rd, ex_mem_regwrite,
           mem_wb_rd, mem_wb_regwrite,
    input  forward_sel, id_mul_bypass, pc_write, if_id_write, id_ex_bubble,
           mul_busy, mul_done, mul_wb_rd, stall_cnt
  );

  modport slave (
    input  id_src, id_src_valid, id_mul_start, id_mul_rd, id_ex_src,
           id_ex_mem_read, id_ex_rd, ex_mem_rd, ex_mem_regwrite,
           mem_wb_rd, mem_wb_regwrite,
    output forward_sel, id_mul_bypass, pc_write, if_id_write, id_ex_bubble,
           mul_busy, mul_done, mul_wb_rd, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Per-source operand forwarding, load-use and multiplier hazard detection with
// a multicycle-multiply scoreboard FSM and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int NUM_SRC     = 2,
  parameter int REG_W       = 5,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         reset,
  fwd_hazard_if.slave bus
);
  localparam int              CW       = $clog2(MUL_LATENCY) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [REG_W-1:0] ZERO_RD = {REG_W{1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [REG_W-1:0]   mul_rd_r, mul_rd_s;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [2*NUM_SRC-1:0] fwd_s;
  logic [NUM_SRC-1:0] byp_s;
  logic load_match_s, mul_match_s;
  logic busy_s, cnt_zero_s, pending_s, done_s;
  logic load_haz_s, raw_haz_s, struct_haz_s, stall_s, accept_s;

  // Independent forward select for each EX-stage source; EX/MEM outranks MEM/WB
  always_comb begin
    fwd_s = {2*NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.ex_mem_regwrite && (bus.ex_mem_rd != ZERO_RD) &&
          (bus.ex_mem_rd == bus.id_ex_src[i*REG_W +: REG_W])) begin
        fwd_s[2*i +: 2] = 2'b10;
      end else if (bus.mem_wb_regwrite && (bus.mem_wb_rd != ZERO_RD) &&
                   (bus.mem_wb_rd == bus.id_ex_src[i*REG_W +: REG_W])) begin
        fwd_s[2*i +: 2] = 2'b01;
      end else begin
        fwd_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // ID-stage source matches against the load destination and the pending multiply
  always_comb begin
    load_match_s = 1'b0;
    mul_match_s  = 1'b0;
    byp_s        = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      load_match_s = load_match_s | (bus.id_src_valid[i] &
                     (bus.id_src[i*REG_W +: REG_W] == bus.id_ex_rd));
      mul_match_s  = mul_match_s | (bus.id_src_valid[i] &
                     (bus.id_src[i*REG_W +: REG_W] == mul_rd_r));
      byp_s[i]     = done_s & (mul_rd_r != ZERO_RD) & bus.id_src_valid[i] &
                     (bus.id_src[i*REG_W +: REG_W] == mul_rd_r);
    end
  end

  assign busy_s       = (state_r == BUSY);
  assign cnt_zero_s   = (cnt_r == CNT_ZERO);
  assign pending_s    = busy_s & ~cnt_zero_s;
  assign done_s       = busy_s & cnt_zero_s;
  assign load_haz_s   = bus.id_ex_mem_read & (bus.id_ex_rd != ZERO_RD) & load_match_s;
  assign raw_haz_s    = pending_s & (mul_rd_r != ZERO_RD) & mul_match_s;
  assign struct_haz_s = pending_s & bus.id_mul_start;
  assign stall_s      = load_haz_s | raw_haz_s | struct_haz_s;
  // A new multiply may enter on the done cycle, giving back-to-back issue
  assign accept_s     = bus.id_mul_start & ~stall_s & (~busy_s | cnt_zero_s);

  // Scoreboard next-state: load on accept, count down while busy, retire at zero
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    mul_rd_s = mul_rd_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s  = BUSY;
          cnt_s    = CNT_LOAD;
          mul_rd_s = bus.id_mul_rd;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (accept_s) begin
          state_s  = BUSY;
          cnt_s    = CNT_LOAD;
          mul_rd_s = bus.id_mul_rd;
        end else if (cnt_zero_s) begin
          state_s  = IDLE;
        end else begin
          cnt_s    = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = CNT_ZERO;
        mul_rd_s = ZERO_RD;
      end
    endcase
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      mul_rd_r <= ZERO_RD;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      mul_rd_r <= mul_rd_s;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.forward_sel   = fwd_s;
  assign bus.id_mul_bypass = byp_s;
  assign bus.pc_write      = ~stall_s;
  assign bus.if_id_write   = ~stall_s;
  assign bus.id_ex_bubble  = stall_s;
  assign bus.mul_busy      = busy_s;
  assign bus.mul_done      = done_s;
  assign bus.mul_wb_rd     = mul_rd_r;
  assign bus.stall_cnt     = stall_cnt_r;
endmodule
